// File: rtl/core_pkg.sv
// Shared core definitions: bus widths, AXI response codes and the fetch
// bus-master state encoding.
package core_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } fetch_state_t;

    // Instruction fetches must be word aligned.
    function automatic logic addr_misaligned(input logic [1:0] byte_offset);
        return byte_offset != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_axil_master.sv
// AXI-lite read master for instruction fetch: one PC in flight, single AR/R
// beat per request, flush-safe (an issued transaction always completes on the bus).
module fetch_axil_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  flush,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,

    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP
);
    import core_pkg::*;

    fetch_state_t          state_reg,      state_next;
    logic [ADDR_WIDTH-1:0] araddr_reg,     araddr_next;
    logic                  arvalid_reg,    arvalid_next;
    logic                  rready_reg,     rready_next;
    logic                  resp_valid_reg, resp_valid_next;
    logic [DATA_WIDTH-1:0] resp_data_reg,  resp_data_next;
    logic                  resp_err_reg,   resp_err_next;
    logic                  discard_reg,    discard_next;

    logic req_fire;
    logic ar_fire;
    logic r_fire;
    logic resp_fire;
    logic drop_beat;
    logic req_bad_align;

    assign req_ready     = (state_reg == IDLE) && !flush;
    assign req_fire      = req_valid && req_ready;
    assign ar_fire       = arvalid_reg && ARREADY;
    assign r_fire        = RVALID && rready_reg;
    assign resp_fire     = resp_valid_reg && resp_ready;
    assign req_bad_align = addr_misaligned(req_addr[1:0]);

    // A flush arriving in the same cycle as the R beat also kills that beat.
    assign drop_beat     = discard_reg || flush;

    // State register and capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            araddr_reg     <= '0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            discard_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            araddr_reg     <= araddr_next;
            arvalid_reg    <= arvalid_next;
            rready_reg     <= rready_next;
            resp_valid_reg <= resp_valid_next;
            resp_data_reg  <= resp_data_next;
            resp_err_reg   <= resp_err_next;
            discard_reg    <= discard_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_fire) begin
                    state_next = req_bad_align ? RESP : ADDR;
                end
            end
            ADDR: begin
                if (ar_fire) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (r_fire) begin
                    state_next = drop_beat ? IDLE : RESP;
                end
            end
            RESP: begin
                if (flush || resp_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Register next values for the bus and response outputs
    always_comb begin
        araddr_next     = araddr_reg;
        arvalid_next    = arvalid_reg;
        rready_next     = rready_reg;
        resp_valid_next = resp_valid_reg;
        resp_data_next  = resp_data_reg;
        resp_err_next   = resp_err_reg;
        discard_next    = discard_reg;

        unique case (state_reg)
            IDLE: begin
                if (req_fire) begin
                    if (req_bad_align) begin
                        resp_data_next  = '0;
                        resp_err_next   = 1'b1;
                        resp_valid_next = 1'b1;
                    end else begin
                        araddr_next  = req_addr;
                        arvalid_next = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (flush) begin
                    discard_next = 1'b1;
                end
                if (ar_fire) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                end
            end
            DATA: begin
                if (flush) begin
                    discard_next = 1'b1;
                end
                if (r_fire) begin
                    rready_next = 1'b0;
                    if (drop_beat) begin
                        discard_next = 1'b0;
                    end else begin
                        resp_data_next  = RDATA;
                        resp_err_next   = (RRESP != AXI_RESP_OKAY);
                        resp_valid_next = 1'b1;
                    end
                end
            end
            RESP: begin
                if (flush || resp_fire) begin
                    resp_valid_next = 1'b0;
                end
            end
            default: begin
                arvalid_next    = 1'b0;
                rready_next     = 1'b0;
                resp_valid_next = 1'b0;
                discard_next    = 1'b0;
            end
        endcase
    end

    assign ARVALID    = arvalid_reg;
    assign ARADDR     = araddr_reg;
    assign RREADY     = rready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_fetch_axil_master.sv
// Bench for fetch_axil_master: configurable AXI-lite responder, response
// scoreboard, vector table and cycle-exact corner-case sequences.
module tb_fetch_axil_master;
    import core_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, flush;
    logic [AW-1:0] req_addr;
    logic          resp_valid, resp_ready, resp_err;
    logic [DW-1:0] resp_data;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [AW-1:0] ARADDR;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;

    always #5 clk = ~clk;

    fetch_axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        int          stall;
        int          dly;
        bit          err;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    resp_t sb_q[$];

    logic [31:0] mem [0:63];
    int ar_stall_cfg = 0;
    int r_delay_cfg  = 0;
    bit err_cfg      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responder: ARREADY held low for ar_stall_cfg cycles of ARVALID, RVALID
    // raised r_delay_cfg cycles after the AR handshake.
    initial begin : responder
        bit          ar_hs, r_hs, pend;
        logic [31:0] cap_addr, rd_addr;
        int          cnt, rdly;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        pend = 0; cnt = 0; rdly = 0; rd_addr = '0;
        forever begin
            @(negedge clk);
            ar_hs    = ARVALID && ARREADY;
            r_hs     = RVALID && RREADY;
            cap_addr = ARADDR;
            if (ARVALID && !ARREADY) cnt++;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ARREADY = 1'b0; RVALID = 1'b0; pend = 0; cnt = 0; rdly = 0;
            end else begin
                if (r_hs) RVALID = 1'b0;
                if (ar_hs) begin
                    pend = 1; rd_addr = cap_addr; rdly = r_delay_cfg; cnt = 0;
                end else if (pend && rdly > 0) begin
                    rdly--;
                end
                if (pend && rdly == 0 && !RVALID) begin
                    RVALID = 1'b1;
                    RDATA  = err_cfg ? 32'hDEAD_BEEF : mem[rd_addr[7:2]];
                    RRESP  = err_cfg ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    pend   = 0;
                end
                ARREADY = (cnt >= ar_stall_cfg);
            end
        end
    end

    // Scoreboard consumer: a response handshake not killed by flush must match the queue head.
    initial begin : monitor
        resp_t exp;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && resp_valid && resp_ready && !flush) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got data 0x%08h err %0b, want no response", resp_data, resp_err);
                end else begin
                    exp = sb_q.pop_front();
                    $display("txn resp data=0x%08h err=%0b (expect 0x%08h/%0b)", resp_data, resp_err, exp.data, exp.err);
                    chk("resp_data", resp_data, exp.data);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, exp.err});
                end
            end
        end
    end

    // Present a request from a posedge+1 point; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [31:0] a, input bit push, input logic [31:0] ed, input bit ee);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: got req_ready=0, want 1 within 50 cycles");
        end else if (push) begin
            sb_q.push_back(resp_t'{data: ed, err: ee});
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || !req_ready) && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending, want 0 within 100 cycles", name, sb_q.size());
            sb_q.delete();
        end
        tick();
    endtask

    task automatic wait_resp_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL %s_resp_timeout: got resp_valid=0, want 1 within 50 cycles", name);
        end
    endtask

    task automatic set_cfg(input int stall, input int dly, input bit err);
        ar_stall_cfg = stall;
        r_delay_cfg  = dly;
        err_cfg      = err;
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs[7];

        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[4] = 32'h0000_0013;

        vecs[0] = '{32'h10, 0, 0, 0, 32'h0000_0013, 0};
        vecs[1] = '{32'h20, 3, 0, 0, 32'hC0DE_0008, 0};
        vecs[2] = '{32'h30, 0, 0, 1, 32'hDEAD_BEEF, 1};
        vecs[3] = '{32'h06, 0, 0, 0, 32'h0000_0000, 1};
        vecs[4] = '{32'h24, 1, 2, 0, 32'hC0DE_0009, 0};
        vecs[5] = '{32'h3C, 2, 1, 1, 32'hDEAD_BEEF, 1};
        vecs[6] = '{32'h01, 0, 0, 0, 32'h0000_0000, 1};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", {31'd0, ARVALID}, 32'd0);
        chk("rst_araddr", ARADDR, 32'd0);
        chk("rst_rready", {31'd0, RREADY}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            set_cfg(vecs[i].stall, vecs[i].dly, vecs[i].err);
            send(vecs[i].addr, 1, vecs[i].exp_data, vecs[i].exp_err);
            drain($sformatf("vec%0d", i));
        end

        // Latency with an always-ready responder
        set_cfg(0, 0, 0);
        send(32'h10, 1, 32'h0000_0013, 0);
        @(negedge clk);
        chk("lat_c1_arvalid", {31'd0, ARVALID}, 32'd1);
        chk("lat_c1_araddr", ARADDR, 32'h10);
        @(negedge clk);
        chk("lat_c2_rready", {31'd0, RREADY}, 32'd1);
        chk("lat_c2_arvalid", {31'd0, ARVALID}, 32'd0);
        @(negedge clk);
        chk("lat_c3_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("lat_c3_resp_data", resp_data, 32'h0000_0013);
        @(negedge clk);
        chk("lat_c4_req_ready", {31'd0, req_ready}, 32'd1);
        tick();

        // AR stall: address phase held stable for 4 cycles
        set_cfg(3, 0, 0);
        send(32'h20, 1, 32'hC0DE_0008, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("stall_c%0d_arvalid", c), {31'd0, ARVALID}, 32'd1);
            chk($sformatf("stall_c%0d_araddr", c), ARADDR, 32'h20);
        end
        @(negedge clk);
        chk("stall_c5_rready", {31'd0, RREADY}, 32'd1);
        @(negedge clk);
        chk("stall_c6_resp_valid", {31'd0, resp_valid}, 32'd1);
        drain("stall");

        // Flush in DATA while the R beat is late: beat swallowed, no response
        set_cfg(0, 2, 0);
        send(32'h28, 0, 32'h0, 0);
        @(negedge clk);
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_c2_rready", {31'd0, RREADY}, 32'd1);
        chk("fl_c2_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_c3_rready", {31'd0, RREADY}, 32'd1);
        @(negedge clk);
        chk("fl_c4_rready", {31'd0, RREADY}, 32'd1);
        @(negedge clk);
        chk("fl_c5_rready", {31'd0, RREADY}, 32'd0);
        chk("fl_c5_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("fl_c5_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        chk("fl_c6_resp_valid", {31'd0, resp_valid}, 32'd0);
        set_cfg(0, 0, 0);
        send(32'h24, 1, 32'hC0DE_0009, 0);
        drain("after_flush");

        // Back-pressured response held stable
        resp_ready = 1'b0;
        send(32'h10, 1, 32'h0000_0013, 0);
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_resp_valid", c), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp%0d_resp_data", c), resp_data, 32'h0000_0013);
            chk($sformatf("bp%0d_req_ready", c), {31'd0, req_ready}, 32'd0);
            chk($sformatf("bp%0d_arvalid", c), {31'd0, ARVALID}, 32'd0);
        end
        tick();
        resp_ready = 1'b1;
        drain("backpressure");

        // Asynchronous reset in the middle of ADDR
        set_cfg(10, 0, 0);
        send(32'h20, 0, 32'h0, 0);
        @(negedge clk);
        chk("mr_arvalid_before", {31'd0, ARVALID}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr_arvalid", {31'd0, ARVALID}, 32'd0);
        chk("mr_araddr", ARADDR, 32'd0);
        chk("mr_rready", {31'd0, RREADY}, 32'd0);
        chk("mr_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mr_resp_data", resp_data, 32'd0);
        chk("mr_resp_err", {31'd0, resp_err}, 32'd0);
        chk("mr_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        set_cfg(0, 0, 0);
        send(32'h24, 1, 32'hC0DE_0009, 0);
        drain("after_reset");

        // Flush in RESP drops the response even with resp_ready high
        resp_ready = 1'b0;
        send(32'h30, 0, 32'h0, 0);
        wait_resp_valid("flush_resp");
        tick();
        flush = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("fr_req_ready_flush", {31'd0, req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fr_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("fr_req_ready", {31'd0, req_ready}, 32'd1);
        tick();

        // Misaligned: no bus access, error response next cycle
        send(32'h06, 1, 32'h0, 1);
        @(negedge clk);
        chk("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("mis_arvalid", {31'd0, ARVALID}, 32'd0);
        @(negedge clk);
        chk("mis_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mis_arvalid_after", {31'd0, ARVALID}, 32'd0);
        drain("misaligned");

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
